// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one command byte to a PS/2 device: inhibits the clock line for
// 100 us, issues the start bit, then shifts out 8 data bits (LSB first), odd
// parity and the stop bit on the device-generated falling clock edges, and
// finally samples the device ACK. A 20 ms watchdog, counted from START entry,
// aborts a stalled frame.
//
// Optional feature: define PS2_TX_ACK_CHECK_EN to report a missing ACK
// (data high on edge 11) as tx_error instead of tx_done.
//
// Ports:
//   clock, reset_n         system clock (rising edge), async active-low reset
//   ps2_clock, ps2_data    PS/2 pad inputs (asynchronous)
//   ps2_clock_oe           1 = pull clock pad low, 0 = release
//   ps2_data_oe            1 = pull data pad low, 0 = release
//   tx_data, tx_valid      command byte and send request
//   tx_ready               high only while idle
//   tx_done, tx_error      one-cycle completion / failure pulses
module ps2_host_tx #(
  parameter int clk_freq = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_CYCLES = clk_freq / 10000;
  localparam int WD_CYCLES  = clk_freq / 50;
  localparam int CNT_W      = $clog2(WD_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(WD_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_PARITY    = 3'd4;
  localparam logic [2:0] S_STOP      = 3'd5;
  localparam logic [2:0] S_ACK       = 3'd6;
  localparam logic [2:0] S_WAIT_IDLE = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;      // inhibit timer, then watchdog
  logic [8:0]       shift_q, shift_d;  // {parity, data}
  logic [2:0]       idx_q, idx_d;
  logic             drive_q, drive_d;  // data_oe level while shifting bits
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [2:0]       clk_s_q;           // [1] synchronized, [2] its previous value
  logic [1:0]       data_s_q;

  logic clk_s, data_s, fall, wd_active;

  assign clk_s     = clk_s_q[1];
  assign data_s    = data_s_q[1];
  assign fall      = clk_s_q[2] & ~clk_s_q[1];
  assign wd_active = (state_q != S_IDLE) && (state_q != S_INHIBIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    drive_d = drive_q;
    ack_d   = ack_q;
    done_d  = 1'b0;
    error_d = 1'b0;

    if (wd_active) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d = {~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;  // watchdog starts from START entry
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        if (fall) begin
          drive_d = ~shift_q[0];
          idx_d   = 3'd1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          drive_d = ~shift_q[idx_q];
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          drive_d = ~shift_q[8];
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          drive_d = 1'b0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_d   = data_s;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_d = S_IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
          if (ack_q) error_d = 1'b1;
          else       done_d  = 1'b1;
`else
          done_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog overrides any completion in the same cycle.
    if (wd_active && cnt_q == WD_LAST) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      drive_q  <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      clk_s_q  <= 3'b111;
      data_s_q <= 2'b11;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      drive_q  <= drive_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      error_q  <= error_d;
      clk_s_q  <= {clk_s_q[1:0], ps2_clock};
      data_s_q <= {data_s_q[0], ps2_data};
    end
  end

  // Output enables decode straight from registered state so that reset
  // releases both lines without waiting for a clock edge.
  always_comb begin
    ps2_clock_oe = (state_q == S_INHIBIT);
    case (state_q)
      S_INHIBIT:                 ps2_data_oe = (cnt_q == INH_LAST);
      S_START:                   ps2_data_oe = 1'b1;
      S_DATA, S_PARITY, S_STOP:  ps2_data_oe = drive_q;
      default:                   ps2_data_oe = 1'b0;
    endcase
  end

  assign tx_ready = (state_q == S_IDLE);
  assign tx_done  = done_q;
  assign tx_error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int CLK_FREQ = 1000000;
  localparam int INH      = CLK_FREQ / 10000;
  localparam int WD       = CLK_FREQ / 50;
  localparam int H        = 15;
  localparam int BOUND    = 40000;

  typedef struct {
    bit         is_err;
    bit         timeout;
    logic [9:0] frame;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       dev_enable = 1'b1;
  logic       dev_ack = 1'b1;
  logic       dev_busy = 1'b0;
  int         dev_edges = 0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clock_oe, ps2_data_oe, tx_ready, tx_done, tx_error;
  logic       line_clk, line_data;

  exp_t       exp_q[$];
  logic [9:0] obs_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  assign line_clk  = dev_clk & ~ps2_clock_oe;
  assign line_data = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.clk_freq(CLK_FREQ)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ps2_clock    (line_clk),
    .ps2_data     (line_data),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .tx_error     (tx_error)
  );

  always #5 clock = ~clock;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Line levels of a frame as the device sees them: data LSB first, odd parity, stop 1.
  function automatic logic [9:0] line_frame(input logic [7:0] d);
    bit p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d};
  endfunction

  // Device: waits for a request-to-send, clocks 11 pulses, samples on rising edges.
  initial begin : device
    logic [9:0] bits;
    bits = '0;
    forever begin
      @(negedge clock);
      if (ps2_clock_oe) begin
        while (ps2_clock_oe) @(negedge clock);
        if (dev_enable && !line_data) begin
          dev_busy = 1'b1;
          repeat (H) @(negedge clock);
          for (int i = 1; i <= 11; i++) begin
            if (i == 11) dev_data = dev_ack ? 1'b0 : 1'b1;
            dev_clk   = 1'b0;
            dev_edges = i;
            repeat (H) @(negedge clock);
            dev_clk = 1'b1;
            if (i <= 10) bits[i-1] = line_data;
            if (i == 10) obs_q.push_back(bits);
            repeat (H) @(negedge clock);
          end
          dev_data  = 1'b1;
          dev_edges = 0;
          dev_busy  = 1'b0;
        end
      end
    end
  end

  // Monitor: inhibit shape, watchdog latency and completion scoreboard.
  initial begin : monitor
    exp_t       e;
    logic [9:0] f;
    int         inh_len, start_cyc;
    bit         inh_early, prev_doe;
    inh_len = 0; start_cyc = 0; inh_early = 0; prev_doe = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        inh_len = 0;
        inh_early = 0;
      end else begin
        if (ps2_clock_oe) begin
          if (inh_len > 0 && prev_doe) inh_early = 1;
          inh_len++;
        end else if (inh_len > 0) begin
          check(inh_len == INH, "inhibit_length", inh_len, INH);
          check(prev_doe && !inh_early, "inhibit_data_oe_last_only", {inh_early, prev_doe}, 1);
          check(ps2_data_oe, "start_bit_driven", ps2_data_oe, 1);
          start_cyc = cyc;
          inh_len = 0;
          inh_early = 0;
        end
        if (tx_done || tx_error) begin
          check(!(tx_done && tx_error), "done_error_exclusive", {tx_done, tx_error}, 2'b01);
          check(exp_q.size() != 0, "unexpected_completion", {tx_done, tx_error}, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tx_error == e.is_err, "completion_kind_error", tx_error, e.is_err);
            if (e.timeout) begin
              check(cyc - start_cyc == WD, "watchdog_latency", cyc - start_cyc, WD);
              check(!ps2_clock_oe && !ps2_data_oe, "timeout_lines_released",
                    {ps2_clock_oe, ps2_data_oe}, 0);
            end else begin
              check(obs_q.size() != 0, "frame_observed", obs_q.size(), 1);
              if (obs_q.size() != 0) begin
                f = obs_q.pop_front();
                check(f == e.frame, "frame_bits", f, e.frame);
              end
            end
          end
        end
      end
      prev_doe = ps2_data_oe;
    end
  end

  task automatic send(input logic [7:0] d, input bit ack, input bit to, input bit expect_done);
    exp_t e;
    int   n;
    n = 0;
    while (!tx_ready && n < BOUND) begin @(negedge clock); n++; end
    check(tx_ready, "ready_before_send", tx_ready, 1);
    dev_ack   = ack;
    e.frame   = line_frame(d);
    e.timeout = to;
`ifdef PS2_TX_ACK_CHECK_EN
    e.is_err  = to || !ack;
`else
    e.is_err  = to;
`endif
    if (expect_done) exp_q.push_back(e);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check(!tx_ready, "ready_drop_after_accept", tx_ready, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dev_busy) && n < BOUND) begin @(negedge clock); n++; end
    check(n < BOUND, "completion_within_bound", n, BOUND);
    repeat (10) @(negedge clock);
  endtask

  task automatic wait_edge(input int k);
    int n;
    n = 0;
    while (dev_edges < k && n < BOUND) begin @(negedge clock); n++; end
    check(dev_edges >= k, "device_edge_reached", dev_edges, k);
  endtask

  initial begin : stimulus
    int  n;
    bit  spurious;
    logic [7:0] d;

    repeat (3) @(negedge clock);
    check(tx_ready, "reset_tx_ready", tx_ready, 1);
    check(!ps2_clock_oe && !ps2_data_oe, "reset_oe", {ps2_clock_oe, ps2_data_oe}, 0);
    check(!tx_done && !tx_error, "reset_pulses", {tx_done, tx_error}, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    send(8'hED, 1'b1, 1'b0, 1'b1);
    wait_done();
    send(8'h01, 1'b1, 1'b0, 1'b1);
    wait_done();

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      send(d, ($urandom_range(0, 3) != 0), 1'b0, 1'b1);
      wait_done();
    end

    // Device leaves data high on edge 11.
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_done();

    // A request during a busy frame must be ignored.
    send(8'hF4, 1'b1, 1'b0, 1'b1);
    wait_edge(3);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    check(!tx_ready, "busy_not_ready", tx_ready, 0);
    wait_done();
    spurious = 0;
    for (int i = 0; i < INH + 40; i++) begin
      @(negedge clock);
      if (ps2_clock_oe) spurious = 1;
    end
    check(!spurious, "ignored_request_no_frame", spurious, 0);

    // Reset mid-frame after falling edge 4.
    send(8'($urandom), 1'b1, 1'b0, 1'b0);
    wait_edge(4);
    repeat (6) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check(!ps2_clock_oe && !ps2_data_oe, "async_reset_release", {ps2_clock_oe, ps2_data_oe}, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check(tx_ready, "ready_after_reset_release", tx_ready, 1);
    n = 0;
    while (dev_busy && n < BOUND) begin @(negedge clock); n++; end
    obs_q.delete();
    repeat (10) @(negedge clock);

    // Device never clocks: watchdog.
    dev_enable = 1'b0;
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_done();
    dev_enable = 1'b1;

    send(8'h96, 1'b1, 1'b0, 1'b1);
    wait_done();

    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    check(obs_q.size() == 0, "no_stray_frames", obs_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : global_guard
    #(20000000);
    $display("FAIL global_timeout: actual=%0d cycles required=finish", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule
